// File: rtl/sdp_scan8_if.sv
// sdp_scan8_if: write handshake bundle for the sdp_scan8 display scanner.
//   wr_en     request to stage a new display image (taken only while busy=0)
//   wr_data   8 hex nibbles, digit i = wr_data[4i+3:4i]
//   wr_dp     per-digit decimal point, active-high
//   wr_blank  per-digit blank, active-high
//   wr_blink  per-digit blink enable, active-high
//   busy      a staged image is waiting for the next frame boundary
// master: the producer of display images; slave: the scanner.
interface sdp_scan8_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  wr_blank;
  logic [7:0]  wr_blink;
  logic        busy;

  modport master (
    output wr_en, wr_data, wr_dp, wr_blank, wr_blink,
    input  busy
  );

  modport slave (
    input  wr_en, wr_data, wr_dp, wr_blank, wr_blink,
    output busy
  );
endinterface

// File: rtl/sdp_scan8.sv
// sdp_scan8: time-multiplexed scan controller for the 8-digit active-low
// common-anode seven-segment display.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   wr          write handshake (sdp_scan8_if.slave): image in, busy out
//   frame_tick  one-cycle pulse in the cycle after each completed frame
//   ca..cg, dp  segment / decimal point cathodes, active-low
//   an[7:0]     digit anodes, active-low, an[i] selects digit i
// A written image sits in a staging buffer until the end of the current
// frame, so a frame is never drawn from a mix of old and new data. Each
// digit slot starts with GUARD cycles with every anode off so the shared
// segment bus can settle before the next digit lights.
module sdp_scan8 #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  sdp_scan8_if.slave  wr,
  output logic        frame_tick,
  output logic        ca,
  output logic        cb,
  output logic        cc,
  output logic        cd,
  output logic        ce,
  output logic        cf,
  output logic        cg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Active-high {a..g} pattern for one hex digit.
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: hexseg = 7'b1111110;
      4'h1: hexseg = 7'b0110000;
      4'h2: hexseg = 7'b1101101;
      4'h3: hexseg = 7'b1111001;
      4'h4: hexseg = 7'b0110011;
      4'h5: hexseg = 7'b1011011;
      4'h6: hexseg = 7'b1011111;
      4'h7: hexseg = 7'b1110000;
      4'h8: hexseg = 7'b1111111;
      4'h9: hexseg = 7'b1111011;
      4'hA: hexseg = 7'b1110111;
      4'hB: hexseg = 7'b0011111;
      4'hC: hexseg = 7'b1001110;
      4'hD: hexseg = 7'b0111101;
      4'hE: hexseg = 7'b1001111;
      default: hexseg = 7'b1000111;
    endcase
  endfunction

  // Scan timing state
  logic [PW-1:0] presc_reg;
  logic [2:0]    idx_reg;
  logic [FW-1:0] frame_reg;
  logic          phase_reg;

  // Image buffers
  logic          busy_reg;
  logic [31:0]   stg_data_reg;
  logic [7:0]    stg_dp_reg;
  logic [7:0]    stg_blank_reg;
  logic [7:0]    stg_blink_reg;
  logic [31:0]   act_data_reg;
  logic [7:0]    act_dp_reg;
  logic [7:0]    act_blank_reg;
  logic [7:0]    act_blink_reg;

  // Registered pin drivers
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic          tick_reg;

  logic          slot_end;
  logic          eof;
  logic          accept;
  logic          commit;
  logic          on;
  logic [6:0]    seg_dec [8];
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign slot_end = (presc_reg == PW'(SCAN_DIV - 1));
  assign eof      = slot_end && (idx_reg == 3'd7);
  assign accept   = wr.wr_en && !busy_reg;
  // A write arriving in the commit cycle is dropped because busy is still 1.
  assign commit   = eof && busy_reg;

  // Segment decode for every digit of the active image; the scan index
  // then only has to pick one of eight ready patterns.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign seg_dec[gi] = hexseg(act_data_reg[4*gi +: 4]);
    end
  endgenerate

  assign on = (presc_reg >= PW'(GUARD)) && !act_blank_reg[idx_reg] &&
              !(act_blink_reg[idx_reg] && phase_reg);

  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (on) begin
      an_next  = ~(8'b1 << idx_reg);
      seg_next = ~seg_dec[idx_reg];
      dp_next  = ~act_dp_reg[idx_reg];
    end
  end

  // Slot prescaler, digit index, and blink timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= 3'd0;
      frame_reg <= '0;
      phase_reg <= 1'b0;
    end else begin
      if (slot_end) begin
        presc_reg <= '0;
        idx_reg   <= idx_reg + 3'd1;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      if (eof) begin
        if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
          frame_reg <= '0;
          phase_reg <= ~phase_reg;
        end else begin
          frame_reg <= frame_reg + FW'(1);
        end
      end
    end
  end

  // Staging / active image double buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg      <= 1'b0;
      stg_data_reg  <= '0;
      stg_dp_reg    <= '0;
      stg_blank_reg <= '0;
      stg_blink_reg <= '0;
      act_data_reg  <= '0;
      act_dp_reg    <= '0;
      act_blank_reg <= 8'hFF;
      act_blink_reg <= '0;
    end else if (accept) begin
      busy_reg      <= 1'b1;
      stg_data_reg  <= wr.wr_data;
      stg_dp_reg    <= wr.wr_dp;
      stg_blank_reg <= wr.wr_blank;
      stg_blink_reg <= wr.wr_blink;
    end else if (commit) begin
      busy_reg      <= 1'b0;
      act_data_reg  <= stg_data_reg;
      act_dp_reg    <= stg_dp_reg;
      act_blank_reg <= stg_blank_reg;
      act_blink_reg <= stg_blink_reg;
    end
  end

  // Pin registers: one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg   <= 8'hFF;
      seg_reg  <= 7'h7F;
      dp_reg   <= 1'b1;
      tick_reg <= 1'b0;
    end else begin
      an_reg   <= an_next;
      seg_reg  <= seg_next;
      dp_reg   <= dp_next;
      tick_reg <= eof;
    end
  end

  assign wr.busy    = busy_reg;
  assign frame_tick = tick_reg;
  assign an         = an_reg;
  assign {ca, cb, cc, cd, ce, cf, cg} = seg_reg;
  assign dp         = dp_reg;

endmodule

// File: tb/tb_sdp_scan8.sv
// tb_sdp_scan8: self-checking bench for sdp_scan8 with a small scan
// (SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2, 64-cycle frames). A reference model
// derives slot, digit and blink phase arithmetically from the cycle count
// since reset and predicts every output each cycle.
module tb_sdp_scan8;
  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick, ca, cb, cc, cd, ce, cf, cg, dp;
  logic [7:0] an;

  always #5 clk = ~clk;

  sdp_scan8_if wif ();

  sdp_scan8 #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wif.slave), .frame_tick(frame_tick),
    .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg),
    .dp(dp), .an(an)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpm;
    logic [7:0]  blank;
    logic [7:0]  blink;
  } img_t;

  typedef struct {
    int         t;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       ft;
  } vec_t;

  logic [6:0] hexseg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  img_t m_act, m_stg;
  bit   m_busy;
  int   t;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = '{32'h0, 8'h00, 8'hFF, 8'h00};
    m_stg  = '{32'h0, 8'h00, 8'h00, 8'h00};
    m_busy = 1'b0;
    t      = 0;
  endtask

  // Called between edges (away from posedge); reset takes effect at once.
  task automatic do_reset();
    wif.wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", {ca, cb, cc, cd, ce, cf, cg}, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_busy", wif.busy, 1'b0);
    chk("rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(bit we, logic [31:0] d, logic [7:0] dpm,
                      logic [7:0] bl, logic [7:0] bk);
    int p, idx, f, ph;
    bit on, eof;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] nib;
    wif.wr_en    = we;
    wif.wr_data  = d;
    wif.wr_dp    = dpm;
    wif.wr_blank = bl;
    wif.wr_blink = bk;
    p   = t % SD;
    idx = (t / SD) % 8;
    f   = t / FRAME;
    ph  = (f / BF) % 2;
    eof = (t % FRAME) == FRAME - 1;
    on  = (p >= GD) && !m_act.blank[idx] && !(m_act.blink[idx] && ph == 1);
    nib = m_act.data[4*idx +: 4];
    e_an  = on ? ~(8'h01 << idx) : 8'hFF;
    e_seg = on ? ~hexseg_tab[nib] : 7'h7F;
    e_dp  = on ? ~m_act.dpm[idx] : 1'b1;
    if (we && !m_busy) begin
      m_stg  = '{d, dpm, bl, bk};
      m_busy = 1'b1;
      $display("write t=%0d data=%h dp=%h blank=%h blink=%h accepted",
               t, d, dpm, bl, bk);
    end else if (eof && m_busy) begin
      m_act  = m_stg;
      m_busy = 1'b0;
      if (we) $display("write t=%0d data=%h ignored (commit cycle)", t, d);
    end else if (we) begin
      $display("write t=%0d data=%h ignored (busy)", t, d);
    end
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("seg", {ca, cb, cc, cd, ce, cf, cg}, e_seg);
    chk("dp", dp, e_dp);
    chk("busy", wif.busy, m_busy);
    chk("frame_tick", frame_tick, eof);
    chk("an_exclusive", (an == 8'hFF) || $onehot(~an), 1'b1);
    t++;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    vec_t vecs [10];
    int   viol, ticks, lit;
    wif.wr_en = 1'b0; wif.wr_data = '0; wif.wr_dp = '0;
    wif.wr_blank = '0; wif.wr_blink = '0;

    vecs[0] = '{2,   8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{3,   8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{62,  8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{63,  8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{65,  8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{66,  8'hFE, 7'h01, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{73,  8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{74,  8'hFD, 7'h4F, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{122, 8'h7F, 7'h0F, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{127, 8'h7F, 7'h0F, 1'b1, 1'b0, 1'b1};

    // Reset and first image; a busy-time write of all F must be dropped.
    do_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == 3)       step(1'b1, 32'h76543210, 8'h01, 8'h00, 8'h00);
      else if (c == 10) step(1'b1, 32'hFFFFFFFF, 8'h00, 8'h00, 8'h00);
      else              idle();
      for (int v = 0; v < 10; v++) begin
        if (vecs[v].t == c) begin
          chk("vec_an", an, vecs[v].an);
          chk("vec_seg", {ca, cb, cc, cd, ce, cf, cg}, vecs[v].seg);
          chk("vec_dp", dp, vecs[v].dp);
          chk("vec_busy", wif.busy, vecs[v].busy);
          chk("vec_tick", frame_tick, vecs[v].ft);
        end
      end
    end

    // Blink on digit 3: lit in phase-0 frames only.
    do_reset();
    ticks = 0;
    for (int c = 0; c < 5 * FRAME; c++) begin
      if (c == 0) step(1'b1, 32'h89ABCDEF, 8'h00, 8'h00, 8'h08);
      else        idle();
      if (frame_tick) ticks++;
      if (c == 90 || c == 282) chk("blink_on", an, 8'hF7);
      if (c == 154 || c == 218) chk("blink_off", an, 8'hFF);
    end
    chk("tick_count", ticks, 5);

    // Blank upper digits, then reset while a write is pending.
    do_reset();
    viol = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 0) step(1'b1, 32'h12345678, 8'hFF, 8'hF0, 8'h00);
      else        idle();
      if (c >= FRAME && an[7:4] != 4'hF) viol++;
    end
    chk("blank_upper", viol, 0);
    step(1'b1, 32'hAAAAAAAA, 8'h00, 8'h00, 8'h00);
    idle();
    chk("pending_busy", wif.busy, 1'b1);
    do_reset();
    lit = 0;
    for (int c = 0; c < FRAME + 8; c++) begin
      idle();
      if (an != 8'hFF) lit++;
    end
    chk("dark_after_reset", lit, 0);

    // Randomized writes against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 5) == 0, $urandom, 8'($urandom),
           8'($urandom) & 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
